// File: rtl/scan_pipe_reg.sv
// -----------------------------------------------------------------------------
// scan_pipe_reg
//
// Purpose:
//   A DEPTH-stage, DATA_W-wide data pipeline with a valid bit per stage. The
//   data flops are also stitched into one serial scan chain. Scan shift takes
//   priority over the functional advance. A counter tracks the position within
//   the current chain pass, and a one-cycle pulse marks each completed pass.
//
// Ports:
//   refclk     in   1         single clock, rising edge
//   reset      in   1         synchronous, active-low reset
//   en         in   1         functional pipeline advance enable
//   data_in    in   DATA_W    functional data into stage 0
//   valid_in   in   1         data_in qualifier
//   scan_en    in   1         select scan-shift mode (overrides en)
//   scan_in    in   1         serial scan-chain input
//   data_out   out  DATA_W    last-stage data
//   valid_out  out  1         last-stage valid flag
//   scan_out   out  1         serial scan-chain output (MSB of last stage)
//   scan_cnt   out  CNT_W     shift count within the current chain pass
//   scan_done  out  1         one-cycle pulse after a full chain pass
// -----------------------------------------------------------------------------
module scan_pipe_reg #(
    parameter  int DATA_W    = 5,
    parameter  int DEPTH     = 3,
    localparam int CHAIN_LEN = DATA_W * DEPTH,
    localparam int CNT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              scan_out,
    output logic [CNT_W-1:0]  scan_cnt,
    output logic              scan_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    // All data stages live in one flat vector. Stage i occupies bits
    // [i*DATA_W +: DATA_W]. As a result, the scan chain order
    // (scan_in -> stage[0][0] -> ... -> stage[DEPTH-1][DATA_W-1]) is simply
    // the vector's LSB-to-MSB order, and both shift modes become left shifts.
    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [DEPTH-1:0]     vld_q,   vld_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 done_q,  done_d;

    // Position within a chain pass, wrapping after the last chain bit.
    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_LAST) begin
            return '0;
        end
        return c + CNT_W'(1);
    endfunction

    always_comb begin
        chain_d = chain_q;
        vld_d   = vld_q;
        cnt_d   = '0;          // any non-shift edge abandons a partial pass
        done_d  = 1'b0;

        if (scan_en) begin
            // One bit per edge along the chain; valid bits are not in the chain.
            chain_d = (chain_q << 1) | CHAIN_LEN'(scan_in);
            cnt_d   = cnt_wrap_inc(cnt_q);
            done_d  = (cnt_q == CNT_LAST);
        end else if (en) begin
            // One whole stage per edge.
            chain_d = (chain_q << DATA_W) | CHAIN_LEN'(data_in);
            vld_d   = (vld_q << 1) | DEPTH'(valid_in);
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset) begin
            chain_q <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign data_out  = chain_q[CHAIN_LEN-1 -: DATA_W];
    assign valid_out = vld_q[DEPTH-1];
    assign scan_out  = chain_q[CHAIN_LEN-1];
    assign scan_cnt  = cnt_q;
    assign scan_done = done_q;

endmodule
